// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud generator: oversample, mid-bit and bit-end strobes from a
// D + F/2^FRAC_W divisor, with a double-buffered divisor and start-edge resync.
module uart_baud_gen_frac #(
    parameter int DIV_W  = 20,
    parameter int FRAC_W = 4,
    parameter int OSR    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [DIV_W-1:0]       div_int_i,
    input  logic [FRAC_W-1:0]      div_frac_i,
    input  logic                   div_load_i,
    input  logic                   resync_i,
    output logic                   os_tick_o,
    output logic                   mid_tick_o,
    output logic                   bit_tick_o,
    output logic [$clog2(OSR)-1:0] os_cnt_o,
    output logic                   cfg_err_o
);

    localparam int OS_W = $clog2(OSR);
    localparam int CW   = DIV_W + 1;
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OSR / 2 - 1);

    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pend_valid;
    logic [DIV_W-1:0]  r_clk_cnt;
    logic [FRAC_W-1:0] r_frac_acc;
    logic [OS_W-1:0]   r_os_cnt;
    logic              r_run_q;
    logic              r_os_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;
    logic              r_cfg_err;

    logic              w_act_ok;
    logic              w_run;
    logic [FRAC_W:0]   w_sum;
    logic              w_carry;
    logic [CW-1:0]     w_period_m1;
    logic              w_end;
    logic              w_tick;
    logic              w_mid;
    logic              w_bit;
    logic              w_apply;

    assign w_act_ok = (r_act_int >= DIV_W'(2));
    assign w_run    = en_i && w_act_ok;

    // Period is compared at DIV_W+1 bits so D = 2^DIV_W-1 with a carry still fits.
    assign w_sum       = {1'b0, r_frac_acc} + {1'b0, r_act_frac};
    assign w_carry     = w_sum[FRAC_W];
    assign w_period_m1 = {1'b0, r_act_int} + CW'(w_carry) - CW'(1);
    assign w_end       = ({1'b0, r_clk_cnt} == w_period_m1);

    // r_run_q makes the first running cycle a restart, like resync: first tick D cycles later.
    assign w_tick = w_run && r_run_q && w_end && !resync_i;
    assign w_mid  = w_tick && (r_os_cnt == OS_MID_PRE);
    assign w_bit  = w_tick && (r_os_cnt == OS_LAST);

    // An illegal active divisor never reaches a bit boundary, so it is replaced immediately.
    assign w_apply = r_pend_valid && (!en_i || !w_act_ok || w_bit || resync_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act_int    <= '0;
            r_act_frac   <= '0;
            r_pend_int   <= '0;
            r_pend_frac  <= '0;
            r_pend_valid <= 1'b0;
            r_clk_cnt    <= '0;
            r_frac_acc   <= '0;
            r_os_cnt     <= '0;
            r_run_q      <= 1'b0;
            r_os_tick    <= 1'b0;
            r_mid_tick   <= 1'b0;
            r_bit_tick   <= 1'b0;
            r_cfg_err    <= 1'b1;
        end else begin
            r_run_q    <= w_run;
            r_os_tick  <= w_tick;
            r_mid_tick <= w_mid;
            r_bit_tick <= w_bit;

            if (!w_run || !r_run_q || resync_i) begin
                r_clk_cnt  <= '0;
                r_frac_acc <= '0;
                r_os_cnt   <= '0;
            end else if (w_end) begin
                r_clk_cnt  <= '0;
                r_frac_acc <= w_sum[FRAC_W-1:0];
                r_os_cnt   <= r_os_cnt + OS_W'(1);
            end else begin
                r_clk_cnt  <= r_clk_cnt + DIV_W'(1);
            end

            if (div_load_i) begin
                r_pend_int   <= div_int_i;
                r_pend_frac  <= div_frac_i;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end

            if (w_apply) begin
                r_act_int  <= r_pend_int;
                r_act_frac <= r_pend_frac;
                r_cfg_err  <= (r_pend_int < DIV_W'(2));
            end else begin
                r_cfg_err  <= !w_act_ok;
            end
        end
    end

    assign os_tick_o  = r_os_tick;
    assign mid_tick_o = r_mid_tick;
    assign bit_tick_o = r_bit_tick;
    assign os_cnt_o   = r_os_cnt;
    assign cfg_err_o  = r_cfg_err;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: table of divisors with expected tick
// spacing, plus sequences for bit/mid timing, shadow load, resync, gating and reset.
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [19:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        resync;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [3:0]  os_cnt;
    logic        cfg_err;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    uart_baud_gen_frac #(.DIV_W(20), .FRAC_W(4), .OSR(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .div_load_i (div_load),
        .resync_i   (resync),
        .os_tick_o  (os_tick),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick),
        .os_cnt_o   (os_cnt),
        .cfg_err_o  (cfg_err)
    );

    always #5 clk = ~clk;
    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int f;
        int p[4];
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input int d, input int f,
                           input int p0, input int p1, input int p2, input int p3);
        tbl[i].d = d;
        tbl[i].f = f;
        tbl[i].p = '{p0, p1, p2, p3};
    endtask

    // which: 0 = os_tick, 1 = mid_tick, 2 = bit_tick; e = edge index or -1 on timeout
    task automatic wait_sig(input int which, input int limit, input string nm, output int e);
        e = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && bit_tick)) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no strobe within %0d cycles", nm, limit);
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (os_tick || mid_tick || bit_tick) cnt++;
        end
    endtask

    // Disable, load a divisor, then enable; t0 is the first edge that samples en high.
    task automatic setup(input int d, input int f, output int t0);
        en = 1'b0;
        @(negedge clk);
        div_int  = 20'(d);
        div_frac = 4'(f);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
        chk("cfg_err_after_load", int'(cfg_err), 0);
        en = 1'b1;
        t0 = cyc + 1;
    endtask

    initial begin
        int t0, e, prev, cnt, t_rs;

        set_vec(0, 54, 0,  54, 54, 54, 54);
        set_vec(1, 54, 4,  54, 54, 54, 55);
        set_vec(2, 10, 8,  10, 11, 10, 11);
        set_vec(3, 2,  0,  2,  2,  2,  2);
        set_vec(4, 3,  15, 3,  4,  4,  4);

        rst_n = 1'b0; en = 1'b0; div_int = '0; div_frac = '0; div_load = 1'b0; resync = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_os_tick",  int'(os_tick), 0);
        chk("rst_mid_tick", int'(mid_tick), 0);
        chk("rst_bit_tick", int'(bit_tick), 0);
        chk("rst_os_cnt",   int'(os_cnt), 0);
        chk("rst_cfg_err",  int'(cfg_err), 1);
        rst_n = 1'b1;
        en    = 1'b1;
        count_ticks(20, cnt);
        chk("no_ticks_after_reset", cnt, 0);

        // Illegal divisor while enabled, then the smallest legal one.
        div_int = 20'd1; div_frac = '0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        count_ticks(20, cnt);
        chk("d1_no_ticks", cnt, 0);
        chk("d1_cfg_err", int'(cfg_err), 1);
        div_int = 20'd2; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
        chk("d2_cfg_err", int'(cfg_err), 0);
        wait_sig(0, 20, "d2_first", prev);
        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 20, "d2_tick", e);
            chk("d2_interval", e - prev, 2);
            prev = e;
        end

        // Table: first-tick latency and the following three oversample periods.
        for (int v = 0; v < 5; v++) begin
            setup(tbl[v].d, tbl[v].f, t0);
            prev = t0;
            for (int k = 0; k < 4; k++) begin
                wait_sig(0, 200, "tbl_tick", e);
                chk($sformatf("tbl%0d_period%0d", v, k), e - prev, tbl[v].p[k]);
                prev = e;
            end
        end

        // Integer divisor: mid and bit strobe positions.
        setup(54, 0, t0);
        wait_sig(1, 1000, "int_mid0", e);
        chk("int_mid0_edge", e - t0, 432);
        chk("int_mid0_os_cnt", int'(os_cnt), 8);
        wait_sig(2, 1000, "int_bit0", e);
        chk("int_bit0_edge", e - t0, 864);
        chk("int_bit0_os_cnt", int'(os_cnt), 0);
        prev = e;
        wait_sig(1, 1000, "int_mid1", e);
        chk("int_mid1_after_bit", e - prev, 432);
        wait_sig(2, 1000, "int_bit1", e);
        chk("int_bit1_after_bit", e - prev, 864);

        // Fractional divisor: bit ends must stay on a 868-cycle grid.
        setup(54, 4, t0);
        for (int k = 1; k <= 20; k++) begin
            wait_sig(2, 1000, "frac_bit", e);
            chk($sformatf("frac_bit%0d_edge", k), e - t0, 868 * k);
        end

        // Shadow load: new divisor takes effect only after the bit boundary.
        setup(10, 0, t0);
        prev = t0;
        for (int k = 1; k <= 3; k++) begin
            wait_sig(0, 100, "shadow_pre", e);
            prev = e;
        end
        div_int = 20'd20; div_frac = '0; div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        for (int k = 4; k <= 16; k++) begin
            wait_sig(0, 100, "shadow_old", e);
            chk($sformatf("shadow_old_period%0d", k), e - prev, 10);
            prev = e;
        end
        chk("shadow_bit_tick", int'(bit_tick), 1);
        chk("shadow_bit_edge", e - t0, 160);
        for (int k = 0; k < 2; k++) begin
            wait_sig(0, 100, "shadow_new", e);
            chk($sformatf("shadow_new_period%0d", k), e - prev, 20);
            prev = e;
        end

        // Resync at os_cnt=7, clk_cnt=5.
        setup(10, 0, t0);
        for (int k = 1; k <= 7; k++) wait_sig(0, 100, "rs_pre", e);
        chk("rs_pre_os_cnt", int'(os_cnt), 7);
        repeat (5) @(negedge clk);
        resync = 1'b1;
        t_rs = cyc + 1;
        @(negedge clk);
        resync = 1'b0;
        wait_sig(0, 100, "rs_next", e);
        chk("rs_next_edge", e - t_rs, 10);
        chk("rs_next_os_cnt", int'(os_cnt), 1);

        // Resync on the exact edge a tick is due: that tick is dropped.
        prev = e;
        repeat (9) @(negedge clk);
        resync = 1'b1;
        t_rs = cyc + 1;
        @(negedge clk);
        resync = 1'b0;
        chk("rs_coincident_dropped", int'(os_tick), 0);
        wait_sig(0, 100, "rs2_next", e);
        chk("rs2_next_edge", e - t_rs, 10);
        chk("rs2_next_os_cnt", int'(os_cnt), 1);

        // Enable dropped for three cycles mid-bit.
        repeat (4) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gate_no_tick", int'(os_tick), 0);
            chk("gate_os_cnt", int'(os_cnt), 0);
        end
        en = 1'b1;
        t0 = cyc + 1;
        wait_sig(0, 100, "gate_first", e);
        chk("gate_first_edge", e - t0, 10);
        chk("gate_first_os_cnt", int'(os_cnt), 1);

        // Reset asserted on the edge where a tick is due.
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_os_tick",  int'(os_tick), 0);
        chk("midrst_mid_tick", int'(mid_tick), 0);
        chk("midrst_bit_tick", int'(bit_tick), 0);
        chk("midrst_os_cnt",   int'(os_cnt), 0);
        chk("midrst_cfg_err",  int'(cfg_err), 1);
        rst_n = 1'b1;
        count_ticks(30, cnt);
        chk("midrst_no_ticks", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
